// File: rtl/interval_timer_pkg.sv
// Shared types and helpers for interval_timer and its optional tick prescaler
// (enabled with INTERVAL_TIMER_PRESCALE_EN).
package interval_timer_pkg;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   // Ceiling log2, never below 1 so a counter always has at least one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(n)) w++;
      return w;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clock by PRESCALE_DIV into a one-cycle Strobe; only instantiated by
// interval_timer when INTERVAL_TIMER_PRESCALE_EN is defined.
module tick_prescaler
   import interval_timer_pkg::*;
#(
   parameter int unsigned PRESCALE_DIV = 50000000
) (
   input  logic clock,
   input  logic Reset,
   input  logic Clear,
   input  logic Enable,
   output logic Strobe
);

   localparam int unsigned CNT_W = clog2(PRESCALE_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE_DIV - 1);

   logic [CNT_W-1:0] div_count;

   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         div_count <= '0;
      end else if (Clear) begin
         div_count <= '0;
      end else if (Enable) begin
         div_count <= (div_count == LAST) ? '0 : div_count + CNT_W'(1);
      end
   end

   // Strobe on the last phase so the first tick lands PRESCALE_DIV cycles after Clear.
   assign Strobe = Enable & (div_count == LAST);

endmodule

// File: rtl/interval_timer.sv
// One-shot / periodic tick timer with pause and abort. Define
// INTERVAL_TIMER_PRESCALE_EN to derive ticks from clock instead of Hz_1_Enable.
module interval_timer
   import interval_timer_pkg::*;
#(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned PRESCALE_DIV = 50000000
) (
   input  logic             clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] Value,
   input  logic             Mode,
   input  logic             Hz_1_Enable,
   input  logic             Start_Timer,
   input  logic             Stop_Timer,
   input  logic             Pause,
   output logic             Expired,
   output logic             Busy,
   output logic [WIDTH-1:0] Count
);

   state_t           state;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_inc;
   logic [WIDTH-1:0] value_q;
   logic             mode_q;
   logic             expired;
   logic             tick_src;
   logic             tick;

`ifdef INTERVAL_TIMER_PRESCALE_EN
   tick_prescaler #(
      .PRESCALE_DIV(PRESCALE_DIV)
   ) u_tick_prescaler (
      .clock (clock),
      .Reset (Reset),
      .Clear (Start_Timer | Stop_Timer),
      .Enable((state == RUN) & ~Pause),
      .Strobe(tick_src)
   );
`else
   assign tick_src = Hz_1_Enable;
`endif

   assign tick      = tick_src & ~Pause & (state == RUN);
   assign count_inc = count + WIDTH'(1);

   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         state   <= IDLE;
         count   <= '0;
         value_q <= '0;
         mode_q  <= MODE_ONESHOT;
         expired <= 1'b0;
      end else begin
         expired <= 1'b0;
         if (Stop_Timer) begin
            state <= IDLE;
            count <= '0;
         end else if (Start_Timer) begin
            value_q <= Value;
            mode_q  <= Mode;
            count   <= '0;
            state   <= RUN;
         end else if (state == RUN) begin
            // A zero terminal expires on the first edge in RUN, independent of ticks or mode.
            if (value_q == '0) begin
               expired <= 1'b1;
               state   <= IDLE;
            end else if (tick) begin
               if (count_inc == value_q) begin
                  expired <= 1'b1;
                  count   <= '0;
                  if (mode_q == MODE_ONESHOT) state <= IDLE;
               end else begin
                  count <= count_inc;
               end
            end
         end
      end
   end

   assign Expired = expired;
   assign Busy    = (state == RUN);
   assign Count   = count;

endmodule

// File: tb/tb_interval_timer.sv
// Randomized bench for interval_timer against a countdown reference model.
module tb_interval_timer;

   localparam int unsigned WIDTH = 4;

   logic             clock;
   logic             Reset;
   logic [WIDTH-1:0] Value;
   logic             Mode;
   logic             Hz_1_Enable;
   logic             Start_Timer;
   logic             Stop_Timer;
   logic             Pause;
   logic             Expired;
   logic             Busy;
   logic [WIDTH-1:0] Count;

   interval_timer #(
      .WIDTH(WIDTH)
   ) dut (
      .clock      (clock),
      .Reset      (Reset),
      .Value      (Value),
      .Mode       (Mode),
      .Hz_1_Enable(Hz_1_Enable),
      .Start_Timer(Start_Timer),
      .Stop_Timer (Stop_Timer),
      .Pause      (Pause),
      .Expired    (Expired),
      .Busy       (Busy),
      .Count      (Count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: ticks remaining until terminal, plus run flag.
   bit m_run;
   bit m_exp;
   bit m_periodic;
   int m_term;
   int m_left;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic int m_count();
      return m_run ? (m_term - m_left) : 0;
   endfunction

   task automatic model_reset();
      m_run      = 0;
      m_exp      = 0;
      m_periodic = 0;
      m_term     = 0;
      m_left     = 0;
   endtask

   task automatic model_edge(input bit stop, input bit start, input bit pause, input bit hz,
                             input int value, input bit mode);
      m_exp = 0;
      if (stop) begin
         m_run = 0;
      end else if (start) begin
         m_run      = 1;
         m_term     = value;
         m_left     = value;
         m_periodic = mode;
      end else if (m_run) begin
         if (m_term == 0) begin
            m_exp = 1;
            m_run = 0;
         end else if (hz && !pause) begin
            m_left--;
            if (m_left == 0) begin
               m_exp = 1;
               if (m_periodic) m_left = m_term;
               else m_run = 0;
            end
         end
      end
   endtask

   task automatic check_outputs(input string where);
      check({where, ".expired"}, int'(Expired), int'(m_exp));
      check({where, ".busy"}, int'(Busy), int'(m_run));
      check({where, ".count"}, int'(Count), m_count());
   endtask

   // Drive one cycle's inputs on the falling edge, then compare after the rising edge.
   task automatic cycle(input bit stop, input bit start, input bit pause, input bit hz,
                        input int value, input bit mode);
      @(negedge clock);
      Stop_Timer  = stop;
      Start_Timer = start;
      Pause       = pause;
      Hz_1_Enable = hz;
      Value       = WIDTH'(value);
      Mode        = mode;
      @(posedge clock);
      model_edge(stop, start, pause, hz, value, mode);
      #1;
      check_outputs("cyc");
   endtask

   task automatic async_reset();
      @(negedge clock);
      Stop_Timer  = 1;
      Start_Timer = 1;
      Value       = WIDTH'(9);
      #2;
      Reset = 1;
      model_reset();
      #1;
      check_outputs("rst_async");
      @(posedge clock);
      #1;
      check_outputs("rst_hold");
      @(negedge clock);
      Reset       = 0;
      Stop_Timer  = 0;
      Start_Timer = 0;
   endtask

   initial begin
      Reset       = 1;
      Value       = '0;
      Mode        = 0;
      Hz_1_Enable = 0;
      Start_Timer = 0;
      Stop_Timer  = 0;
      Pause       = 0;
      model_reset();
      #3;
      check_outputs("reset");
      @(negedge clock);
      Reset = 0;

      // One-shot, value 5, tick every third cycle.
      cycle(0, 1, 0, 0, 5, 0);
      for (int i = 1; i <= 18; i++) cycle(0, 0, 0, (i % 3) == 0, 5, 0);

      // Periodic, value 3, continuous ticks for four periods, then abort.
      cycle(0, 1, 0, 0, 3, 1);
      for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 3, 1);
      cycle(1, 0, 0, 1, 3, 1);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 3, 1);

      // Zero terminal expires with no tick.
      cycle(0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);

      // Retrigger with a coincident tick at count 4 of 6.
      cycle(0, 1, 0, 0, 6, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 6, 0);
      cycle(0, 1, 0, 1, 2, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 2, 0);

      // Pause at count 2 of 5 across ten ticks.
      cycle(0, 1, 0, 0, 5, 0);
      for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 5, 0);
      for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1, 5, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 5, 0);

      // Periodic value 1 with a tick every cycle: pulse per tick.
      cycle(0, 1, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, 1);
      async_reset();

      // Random traffic with occasional asynchronous reset.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            async_reset();
         end else begin
            cycle($urandom_range(0, 59) == 0,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2))
                                              : int'($urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
